// File: rtl/vec_pkg.sv
// Shared vector-datapath constants: op/SEW codes, register-file geometry,
// issue FSM states and the packed command record carried by the queue.
package vec_pkg;

    localparam int VLEN   = 64;
    localparam int VNREG  = 8;
    localparam int RIDX_W = $clog2(VNREG);

    typedef enum logic [1:0] {
        OP_VADD = 2'b00,
        OP_VSUB = 2'b01,
        OP_VMUL = 2'b10,
        OP_VMAC = 2'b11
    } vop_e;

    typedef enum logic [1:0] {
        SEW_8   = 2'b00,
        SEW_16  = 2'b01,
        SEW_32  = 2'b10,
        SEW_ILL = 2'b11
    } vsew_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } state_e;

    typedef struct packed {
        vop_e              op;
        vsew_e             sew;
        logic [RIDX_W-1:0] vd;
        logic [RIDX_W-1:0] vs1;
        logic [RIDX_W-1:0] vs2;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/vcmd_fifo.sv
// Generic synchronous FIFO with registered storage and full/empty flags.
// Latency: pushed word is visible at the head one cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
module vcmd_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push_vld && !full;
    assign do_pop  = pop_rdy && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/vissue_seq.sv
// Vector issue stage: queues commands, reads operands, drives the ALU, writes back.
// Latency: push edge N -> alu_valid_in in cycle N+2 -> writeback at N+3+ALU latency.
// Backpressure: cmd_ready drops when the command queue is full; one command in flight.
module vissue_seq
    import vec_pkg::*;
#(
    parameter int CQ_DEPTH = 4,
    parameter int NREG     = VNREG,
    parameter int TIMEOUT  = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [1:0]              cmd_sew,
    input  logic [$clog2(NREG)-1:0] cmd_vd,
    input  logic [$clog2(NREG)-1:0] cmd_vs1,
    input  logic [$clog2(NREG)-1:0] cmd_vs2,
    input  logic                    rf_we,
    input  logic [$clog2(NREG)-1:0] rf_waddr,
    input  logic [VLEN-1:0]         rf_wdata,
    input  logic [$clog2(NREG)-1:0] rf_raddr,
    output logic [VLEN-1:0]         rf_rdata,
    output logic [1:0]              alu_op,
    output logic [1:0]              alu_sew,
    output logic [VLEN-1:0]         alu_vs1_data,
    output logic [VLEN-1:0]         alu_vs2_data,
    output logic                    alu_valid_in,
    input  logic                    alu_valid_out,
    input  logic [VLEN-1:0]         alu_result,
    output logic                    busy,
    output logic                    err_illegal,
    output logic                    err_timeout,
    output logic [15:0]             retired_count
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e            state, state_n;
    cmd_t              push_cmd;
    cmd_t              head;
    logic [CMD_W-1:0]  head_dat;
    logic              cq_full;
    logic              cq_empty;

    logic [VLEN-1:0]   rf [NREG];
    vop_e              hold_op;
    vsew_e             hold_sew;
    logic [RIDX_W-1:0] hold_vd;
    logic [VLEN-1:0]   hold_a;
    logic [VLEN-1:0]   hold_b;
    logic [TW-1:0]     tmo_cnt;

    logic              pop;
    logic              latch;
    logic              ill_drop;
    logic              wb;
    logic              tmo_hit;
    logic              cnt_clr;
    logic              cnt_inc;

    assign push_cmd = '{op:  vop_e'(cmd_op),
                        sew: vsew_e'(cmd_sew),
                        vd:  RIDX_W'(cmd_vd),
                        vs1: RIDX_W'(cmd_vs1),
                        vs2: RIDX_W'(cmd_vs2)};

    vcmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CQ_DEPTH)
    ) u_cq (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (cmd_valid && cmd_ready),
        .push_dat (push_cmd),
        .pop_rdy  (pop),
        .pop_dat  (head_dat),
        .full     (cq_full),
        .empty    (cq_empty)
    );

    assign head         = cmd_t'(head_dat);
    assign cmd_ready    = !cq_full;
    assign busy         = !cq_empty || (state != IDLE);
    assign rf_rdata     = rf[rf_raddr];
    assign alu_valid_in = (state == ISSUE);
    assign alu_op       = hold_op;
    assign alu_sew      = hold_sew;
    assign alu_vs1_data = hold_a;
    assign alu_vs2_data = hold_b;

    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        latch    = 1'b0;
        ill_drop = 1'b0;
        wb       = 1'b0;
        tmo_hit  = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (!cq_empty) begin
                    pop = 1'b1;
                    if (head.sew == SEW_ILL) begin
                        ill_drop = 1'b1;
                    end else begin
                        latch   = 1'b1;
                        state_n = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_clr = 1'b1;
                state_n = WAIT;
            end
            WAIT: begin
                if (alu_valid_out) begin
                    wb      = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                    // This cycle's increment brings the counter to TIMEOUT.
                    if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        tmo_hit = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            hold_op       <= OP_VADD;
            hold_sew      <= SEW_8;
            hold_vd       <= '0;
            hold_a        <= '0;
            hold_b        <= '0;
            tmo_cnt       <= '0;
            err_illegal   <= 1'b0;
            err_timeout   <= 1'b0;
            retired_count <= '0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            state <= state_n;
            // Writeback is assigned last so it wins a same-index host write.
            if (rf_we) rf[rf_waddr] <= rf_wdata;
            if (wb) begin
                rf[hold_vd]   <= alu_result;
                retired_count <= retired_count + 16'd1;
            end
            if (latch) begin
                hold_op  <= head.op;
                hold_sew <= head.sew;
                hold_vd  <= head.vd;
                hold_a   <= rf[head.vs1];
                hold_b   <= rf[head.vs2];
            end
            if (cnt_clr)      tmo_cnt <= '0;
            else if (cnt_inc) tmo_cnt <= tmo_cnt + 1'b1;
            if (ill_drop) err_illegal <= 1'b1;
            if (tmo_hit)  err_timeout <= 1'b1;
        end
    end

endmodule

// File: doc/vissue_seq.md
Name: vissue_seq

Overview:
Issue/sequencing stage that sits directly upstream of the 64-bit vector ALU. It accepts vector commands into a small in-order queue and reads operands from an 8-entry x 64-bit vector register file. It drives the ALU operand/op/SEW inputs with a single-cycle start pulse, holds them stable until the ALU reports done, then writes the result back to the destination register. Commands are strictly serialised, one in flight, so read-after-write dependencies resolve without forwarding.

Parameters:
CQ_DEPTH, 4, command queue depth (power of 2, >=2)
NREG, 8, number of vector registers (index width = clog2(NREG) = 3)
TIMEOUT, 15, max cycles in WAIT before the command is abandoned

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  queue can accept (= !full)
cmd_op  in  2  00 VADD, 01 VSUB, 10 VMUL, 11 VMAC
cmd_sew  in  2  00 8b, 01 16b, 10 32b, 11 illegal
cmd_vd / cmd_vs1 / cmd_vs2  in  3 each  destination / source register indices
rf_we  in  1  host register write enable
rf_waddr  in  3  host write index
rf_wdata  in  64  host write data
rf_raddr  in  3  host read index
rf_rdata  out  64  combinational read of RF[rf_raddr]
alu_op, alu_sew  out  2 each  to ALU op, sew
alu_vs1_data, alu_vs2_data  out  64 each  to ALU operands
alu_valid_in  out  1  ALU start pulse
alu_valid_out  in  1  ALU result ready
alu_result  in  64  ALU result
busy  out  1  queue non-empty or FSM not in IDLE
err_illegal  out  1  sticky: a command with sew=11 was dropped
err_timeout  out  1  sticky: a command was abandoned in WAIT
retired_count  out  16  commands written back (wraps 0xFFFF->0)

Behaviour:
- Reset (rst_n=0 at posedge): queue empty, FSM=IDLE, all RF entries=0, alu_valid_in=0, alu_op/alu_sew/operand outputs=0, err flags=0, retired_count=0, timeout counter=0. The ALU shares rst_n. A reset in mid-operation drops the in-flight command with no writeback.
- Queue: push when cmd_valid && cmd_ready. Push to an empty queue does not bypass; the head is popped at the earliest on the next cycle. Push and pop in the same cycle are allowed when the queue is not full.
- IDLE: if the queue is non-empty, pop the head. If sew=11, set err_illegal, stay in IDLE, no ALU activity. Otherwise latch op, sew, vd and RF[vs1], RF[vs2] into holding registers. Reads return the pre-write value if a host write hits the same cycle. Go to ISSUE.
- ISSUE: alu_valid_in=1 for exactly this cycle. Go to WAIT and clear the timeout counter.
- WAIT: alu_op/alu_sew/operands stay constant, because the ALU samples them combinationally every computing cycle. alu_valid_in=0.
  - On a cycle with alu_valid_out=1: RF[vd] <= alu_result (full 64 bits; VMAC upper 32 arrive as 0), retired_count++, go to IDLE.
  - Otherwise the counter increments. If the counter reaches TIMEOUT, set err_timeout, go to IDLE, no writeback.
- Holding registers keep their last value in IDLE, so ALU inputs never glitch.
- Latency: for VADD, with push on edge N, alu_valid_in is high in cycle N+2 and writeback occurs on edge N+5. VMUL/VMAC sew8 add 2 cycles; sew16/32 add 1.
- Throughput: one command per (3 + ALU latency) cycles.
- Writeback and host rf_we to the same index in the same cycle: writeback wins. Writes to different indices both occur.
- alu_valid_out outside WAIT is ignored.
- err flags clear only on reset.

Decomposition:
- Shared package vec_pkg: op codes (OP_VADD..OP_VMAC), SEW codes (SEW_8..SEW_32, SEW_ILL=2'b11), VLEN=64, FSM state enum {IDLE, ISSUE, WAIT}. The ALU should import the same constants.
- One sub-module: vcmd_fifo (parameterised synchronous FIFO, width 2+2+3+3+3=13, exposes full/empty).

Test Plan:
- Basic VADD: RF1=0x0102030405060708, RF2=0x0101010101010101; VADD sew8 vd=3 -> RF3=0x0203040506070809, retired_count=1, alu_valid_in high exactly 1 cycle.
- VSUB/VMAC: VSUB sew16 RF3-RF2 -> RF4=0x0102030405060708. VMAC sew8 RF1,RF2 -> RF5=0x0000000000000024.
- Back-to-back and backpressure: 5 pushes while the first executes -> cmd_ready low on the 5th until a pop. All 5 retire in order, retired_count=5. A dependent chain (vd of cmd k = vs1 of cmd k+1) yields correct cumulative values.
- Illegal SEW: a cmd with sew=11 between two valid cmds -> err_illegal=1, no alu_valid_in for it, neighbours retire, retired_count=2.
- Timeout: stub the ALU to never assert valid_out -> after 15 WAIT cycles err_timeout=1, RF[vd] unchanged, FSM in IDLE, next command proceeds.
- Collision and reset: host rf_we to vd on the writeback cycle -> RF holds the ALU result. Assert rst_n=0 during WAIT of a VMUL -> RF all 0, busy=0, no writeback after release.
